// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcode map, FSM state type
// and the result-width derivation.
package alu_seq_pkg;

  localparam int DATA_W_DEF = 4;

  localparam logic [3:0] OP_INC_A = 4'd0;
  localparam logic [3:0] OP_DEC_A = 4'd1;
  localparam logic [3:0] OP_INC_B = 4'd2;
  localparam logic [3:0] OP_DEC_B = 4'd3;
  localparam logic [3:0] OP_PASS_A = 4'd4;
  localparam logic [3:0] OP_MUL   = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_SUB   = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_AND   = 4'd10;
  localparam logic [3:0] OP_OR    = 4'd11;
  localparam logic [3:0] OP_XOR   = 4'd12;
  localparam logic [3:0] OP_NOT_A = 4'd13;
  localparam logic [3:0] OP_NAND  = 4'd14;
  localparam logic [3:0] OP_NOR   = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // The ALU result is a full double-width product-sized value.
  function automatic int res_width(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

// File: rtl/alu_seq_stats.sv
// Saturating operation and stall counters for alu_sequencer; only built when
// ALU_SEQ_STATS_EN is defined.
module alu_seq_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_op_done,
  input  logic        i_stall,
  output logic [15:0] o_stat_ops,
  output logic [15:0] o_stat_stall
);

  logic [15:0] r_ops;
  logic [15:0] r_stall;

  // NOTE: synchronous reset lives inside the clocked block; state uses <= only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ops   <= '0;
      r_stall <= '0;
    end else begin
      if (i_op_done && (r_ops != 16'hFFFF))
        r_ops <= r_ops + 16'd1;
      if (i_stall && (r_stall != 16'hFFFF))
        r_stall <= r_stall + 16'd1;
    end
  end

  assign o_stat_ops   = r_ops;
  assign o_stat_stall = r_stall;

endmodule

// File: rtl/alu_sequencer.sv
// Command-side initiator for the combinational ALU: registers operands, captures
// the result one cycle later and returns it with flags. Optional counters: ALU_SEQ_STATS_EN.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = res_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_use_acc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [RES_W-1:0]  alu_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [3:0]        res_op,
  output logic              res_zero
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_stall
`endif
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_cmd_ready;
  logic   w_res_valid;
  logic   w_accept;
  logic   w_capture;

  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [3:0]        r_alu_sel;
  logic [RES_W-1:0]  r_res_data;
  logic [3:0]        r_res_op;
  logic              r_res_zero;
  // Only the low bits of the accumulator can ever be fed back as operand A.
  logic [DATA_W-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: defaults first so every path assigns every output (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) w_state_nxt = ISSUE;
      end
      ISSUE: w_state_nxt = RESP;
      RESP: begin
        w_res_valid = 1'b1;
        if (res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept  = cmd_valid && w_cmd_ready;
  assign w_capture = (r_state == ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_sel  <= OP_INC_A;
      r_res_data <= '0;
      r_res_op   <= OP_INC_A;
      r_res_zero <= 1'b1;
      r_acc      <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a   <= cmd_use_acc ? r_acc : cmd_a;
        r_alu_b   <= cmd_b;
        r_alu_sel <= cmd_op;
      end
      if (w_capture) begin
        r_res_data <= alu_y;
        r_res_op   <= r_alu_sel;
        r_res_zero <= (alu_y == '0);
        r_acc      <= alu_y[DATA_W-1:0];
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign res_valid = w_res_valid;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign res_data  = r_res_data;
  assign res_op    = r_res_op;
  assign res_zero  = r_res_zero;

`ifdef ALU_SEQ_STATS_EN
  alu_seq_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .i_op_done    (w_res_valid && res_ready),
    .i_stall      (w_res_valid && !res_ready),
    .o_stat_ops   (stat_ops),
    .o_stat_stall (stat_stall)
  );
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU model
// on the alu_a/alu_b/alu_sel/alu_y lines.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int DW = 4;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic          cmd_use_acc;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_sel;
  logic [RW-1:0] alu_y;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_data;
  logic [3:0]    res_op;
  logic          res_zero;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]   stat_ops;
  logic [15:0]   stat_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(DW), .RES_W(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_use_acc (cmd_use_acc),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_y       (alu_y),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_op      (res_op),
    .res_zero    (res_zero)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_ops    (stat_ops),
    .stat_stall  (stat_stall)
`endif
  );

  function automatic logic [RW-1:0] alu_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [3:0] sel);
    logic [RW-1:0] xa;
    logic [RW-1:0] xb;
    xa = {4'h0, a};
    xb = {4'h0, b};
    case (sel)
      OP_INC_A:  return xa + 8'd1;
      OP_DEC_A:  return xa - 8'd1;
      OP_INC_B:  return xb + 8'd1;
      OP_DEC_B:  return xb - 8'd1;
      OP_PASS_A: return xa;
      OP_MUL:    return xa * xb;
      OP_ADD:    return xa + xb;
      OP_SUB:    return xa - xb;
      OP_SHL:    return xa << 1;
      OP_SHR:    return xa >> 1;
      OP_AND:    return xa & xb;
      OP_OR:     return xa | xb;
      OP_XOR:    return xa ^ xb;
      OP_NOT_A:  return {4'h0, ~a};
      OP_NAND:   return {4'h0, ~(a & b)};
      default:   return {4'h0, ~(a | b)};
    endcase
  endfunction

  assign alu_y = alu_model(alu_a, alu_b, alu_sel);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one command from IDLE with res_ready already high.
  task automatic do_cmd(input string tag, input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic use_acc,
                        input logic [DW-1:0] exp_a, input logic [RW-1:0] exp_y,
                        input logic exp_z);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc;
    step();
    cmd_valid = 1'b0; cmd_use_acc = 1'b0;
    check({tag, "_alu_sel"},     16'(alu_sel),   16'(op));
    check({tag, "_alu_a"},       16'(alu_a),     16'(exp_a));
    check({tag, "_alu_b"},       16'(alu_b),     16'(b));
    check({tag, "_issue_valid"}, 16'(res_valid), 16'(1'b0));
    step();
    check({tag, "_res_valid"},   16'(res_valid), 16'(1'b1));
    check({tag, "_res_data"},    16'(res_data),  16'(exp_y));
    check({tag, "_res_op"},      16'(res_op),    16'(op));
    check({tag, "_res_zero"},    16'(res_zero),  16'(exp_z));
    check({tag, "_resp_ready"},  16'(cmd_ready), 16'(1'b0));
    step();
    check({tag, "_done_valid"},  16'(res_valid), 16'(1'b0));
    check({tag, "_done_ready"},  16'(cmd_ready), 16'(1'b1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 16'(cmd_ready), 16'(1'b1));
    check({tag, "_res_valid"}, 16'(res_valid), 16'(1'b0));
    check({tag, "_res_data"},  16'(res_data),  16'(8'h00));
    check({tag, "_res_op"},    16'(res_op),    16'(4'h0));
    check({tag, "_res_zero"},  16'(res_zero),  16'(1'b1));
    check({tag, "_alu_a"},     16'(alu_a),     16'(4'h0));
    check({tag, "_alu_b"},     16'(alu_b),     16'(4'h0));
    check({tag, "_alu_sel"},   16'(alu_sel),   16'(4'h0));
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; res_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check_reset_outputs("rst");

    // Multiply, then add chained through the accumulator.
    do_cmd("mul", 4'b0101, 4'd7, 4'd9, 1'b0, 4'd7, 8'h3F, 1'b0);
    do_cmd("add", 4'b0110, 4'd3, 4'd4, 1'b0, 4'd3, 8'h07, 1'b0);
    do_cmd("acc", 4'b0110, 4'd0, 4'd2, 1'b1, 4'd7, 8'h09, 1'b0);
    do_cmd("sub", 4'b0111, 4'd3, 4'd5, 1'b0, 4'd3, 8'hFE, 1'b0);
    do_cmd("and", 4'b1010, 4'hA, 4'h5, 1'b0, 4'hA, 8'h00, 1'b1);

    // Backpressure from a fresh reset so the counters start at zero.
    rst = 1'b1; step(); rst = 1'b0;
    res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 4'b0110; cmd_a = 4'd1; cmd_b = 4'd1;
    step();
    cmd_valid = 1'b0;
    step();
    check("bp_enter_valid", 16'(res_valid), 16'(1'b1));
    check("bp_enter_data",  16'(res_data),  16'(8'h02));
    cmd_valid = 1'b1; cmd_op = 4'b0110; cmd_a = 4'd5; cmd_b = 4'd5;
    for (int k = 0; k < 10; k++) begin
      step();
      check("bp_valid", 16'(res_valid), 16'(1'b1));
      check("bp_data",  16'(res_data),  16'(8'h02));
      check("bp_ready", 16'(cmd_ready), 16'(1'b0));
      check("bp_alu_a", 16'(alu_a),     16'(4'd1));
    end
`ifdef ALU_SEQ_STATS_EN
    check("stat_stall_10", stat_stall, 16'd10);
    check("stat_ops_0",    stat_ops,   16'd0);
`endif
    res_ready = 1'b1;
    step();
    check("bp_release_valid", 16'(res_valid), 16'(1'b0));
    check("bp_release_ready", 16'(cmd_ready), 16'(1'b1));
`ifdef ALU_SEQ_STATS_EN
    check("stat_ops_1",     stat_ops,   16'd1);
    check("stat_stall_hold", stat_stall, 16'd10);
`endif
    step();
    cmd_valid = 1'b0;
    check("bp_pending_alu_a", 16'(alu_a), 16'(4'd5));
    step();
    check("bp_pending_data", 16'(res_data), 16'(8'h0A));
    step();
    check("bp_pending_idle", 16'(cmd_ready), 16'(1'b1));

    // Reset while the command is in ISSUE: nothing emitted, accumulator cleared.
    cmd_valid = 1'b1; cmd_op = 4'b0110; cmd_a = 4'd3; cmd_b = 4'd3;
    step();
    cmd_valid = 1'b0;
    check("mid_issue_alu_a", 16'(alu_a), 16'(4'd3));
    rst = 1'b1;
    step();
    check_reset_outputs("mid_rst");
    step();
    check("mid_rst_valid2", 16'(res_valid), 16'(1'b0));
    rst = 1'b0;
    do_cmd("acc0", 4'b0110, 4'd9, 4'd1, 1'b1, 4'd0, 8'h01, 1'b0);

    // Back-to-back with cmd_valid held: accepts at edges 1, 4, 7.
    cmd_valid = 1'b1; cmd_op = 4'b0110; cmd_a = 4'd1; cmd_b = 4'd2;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("b2b_cmd_ready", 16'(cmd_ready), 16'((i % 3) == 0));
      check("b2b_res_valid", 16'(res_valid), 16'((i % 3) == 2));
      if ((i % 3) == 1) begin
        check("b2b_alu_a", 16'(alu_a), 16'((i / 3) + 1));
        cmd_a = cmd_a + 4'd1;
      end
      if ((i % 3) == 2)
        check("b2b_res_data", 16'(res_data), 16'(3 + (i / 3)));
    end
    cmd_valid = 1'b0;
    step();
    check("b2b_final_idle", 16'(cmd_ready), 16'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-side initiator for the team's combinational 4-bit ALU datapath. Accepts ALU commands over a valid/ready handshake, drives registered operand and opcode lines into the ALU, and captures the 8-bit result one cycle later. Returns the result with flags over a second valid/ready handshake. Keeps an accumulator so commands can chain on the previous result. Sits between the command source (test sequencer or controller) and the ALU datapath.

## Interface
Parameters:
- DATA_W, 4, operand width; must match the ALU operand width
- RES_W, 2*DATA_W, result width (8 by default)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  ALU opcode (all 16 codes legal)
- cmd_a  in  DATA_W  operand A
- cmd_b  in  DATA_W  operand B
- cmd_use_acc  in  1  substitute acc[DATA_W-1:0] for operand A
- alu_a  out  DATA_W  registered operand A to ALU
- alu_b  out  DATA_W  registered operand B to ALU
- alu_sel  out  4  registered opcode to ALU
- alu_y  in  RES_W  ALU result (combinational from alu_a/alu_b/alu_sel)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  RES_W  captured result
- res_op  out  4  opcode that produced res_data
- res_zero  out  1  res_data == 0

## Operation
- FSM states:
  - IDLE: cmd_ready=1.
    - cmd_valid && cmd_ready: load alu_a (cmd_a, or acc low DATA_W bits when cmd_use_acc), alu_b, and alu_sel.
    - Go to ISSUE.
  - ISSUE: one cycle for the ALU to settle.
    - At the end of the cycle, capture alu_y into res_data, alu_sel into res_op, alu_y into acc, and (alu_y==0) into res_zero.
    - Go to RESP.
  - RESP: res_valid=1; res_data, res_op and res_zero held stable.
    - res_valid && res_ready: go to IDLE.
    - Otherwise stay in RESP.
- cmd_ready is high only in IDLE. Commands presented in other states are not accepted and remain pending at the source.
- alu_a, alu_b and alu_sel hold their last values outside IDLE acceptance. They change only on acceptance.
- alu_y is captured verbatim in RES_W bits; the sequencer performs no truncation or sign handling.
- acc updates only on capture. It is unaffected by backpressure and is overwritten by every completed command.
- res_zero is computed on the captured value, not on live alu_y.

## Timing
- Reset: state=IDLE; cmd_ready=1, res_valid=0, res_data=0, res_op=0, res_zero=1, alu_a=0, alu_b=0, alu_sel=0, acc=0.
- Latency: command accepted at edge E gives res_valid high after edge E+2.
- Minimum initiation interval is 3 cycles: accept, ISSUE, RESP with res_ready=1.
- res_ready held low: the sequencer stays in RESP indefinitely with outputs stable and cmd_ready=0.
- res_ready high with res_valid low is ignored.
- Reset mid-operation (ISSUE or RESP): the in-flight command is discarded, no result is emitted, and acc clears.
- cmd_use_acc on the first command after reset uses acc=0.

## Configuration
- Macro ALU_SEQ_STATS_EN.
- Defined: adds output ports stat_ops [15:0] and stat_stall [15:0], both reset to 0 and both saturating at 16'hFFFF.
  - stat_ops increments on each res handshake.
  - stat_stall increments on each cycle in RESP with res_ready=0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package alu_seq_pkg holds:
  - opcode localparams (OP_INC_A=0 … OP_NOR=15)
  - FSM state typedef (IDLE, ISSUE, RESP)
  - the RES_W derivation
- One sub-module is natural: alu_seq_stats, holding the two saturating counters, instantiated only under ALU_SEQ_STATS_EN.

## Test plan
Bench uses a behavioural ALU model connected to alu_a/alu_b/alu_sel/alu_y.
- Reset, then op=0101, a=7, b=9, res_ready=1 → alu_sel=5 after accept edge; res_valid after 2 edges; res_data=8'h3F; res_op=5; res_zero=0.
- op=0110 a=3 b=4, then op=0110 use_acc=1 b=2 → first res_data=8'h07, second res_data=8'h09 (alu_a=7).
- op=0111 a=3 b=5 → res_data=8'hFE; op=1010 a=4'hA b=4'h5 → res_data=8'h00, res_zero=1.
- res_ready held low for 10 cycles in RESP → res_valid stays 1, res_data stable, cmd_ready=0, new cmd_valid not accepted. With ALU_SEQ_STATS_EN: stat_stall=10, then stat_ops=1 after release.
- Assert rst during ISSUE → no res_valid pulse, all outputs at reset values, and acc=0 (a following use_acc command drives alu_a=0).
- Back-to-back commands with cmd_valid held high and res_ready=1 → accepts spaced exactly 3 cycles apart; results returned in order.
